// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants for the VGA pixel path (timing generator, colour/pattern stages).
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b0;

  typedef logic [CNT_W-1:0] coord_t;

  // Half-open window test [lo, hi), shared by sync decode and region compares downstream.
  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter with advance-enable, terminal-count flag and registered sync decode.
import vga_timing_pkg::*;

module vga_axis_counter #(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter int   BP     = 48,
  parameter logic POL    = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output coord_t       cnt,
  output coord_t       nxt,
  output logic         term,
  output logic         sync
);

  localparam int     TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t SYNC_LO = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_HI = coord_t'(ACTIVE + FP + SYNC);

  // >= rather than == so a corrupted count beyond the end still wraps.
  assign term = (cnt >= LAST);

  always_comb begin
    nxt = cnt;
    if (en) begin
      nxt = term ? '0 : cnt + coord_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= LAST;
      sync <= ~POL;
    end else if (en) begin
      cnt  <= nxt;
      sync <= in_window(nxt, SYNC_LO, SYNC_HI) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: HS/VS, x/y, DE and line/frame strobes, all registered from next-state counts.
// Optional VGA_TIMING_PIXDIV2_EN: advance every second CLK (PIX_EN toggles); otherwise PIX_EN tied high.
import vga_timing_pkg::*;

module vga_timing #(
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic HS_POL   = vga_timing_pkg::HS_POL,
  parameter logic VS_POL   = vga_timing_pkg::VS_POL
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       HS,
  output logic       VS,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       DE,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic       PIX_EN
);

  localparam coord_t H_ACT = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT = coord_t'(V_ACTIVE);

  logic   adv;
  logic   h_term;
  logic   v_term;
  coord_t h_nxt;
  coord_t v_nxt;

`ifdef VGA_TIMING_PIXDIV2_EN
  logic tog;

  // Advance on the edge where tog rises, so PIX_EN is high in the cycle the new outputs appear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tog <= 1'b0;
    end else begin
      tog <= ~tog;
    end
  end

  assign adv    = ~tog;
  assign PIX_EN = tog;
`else
  assign adv    = 1'b1;
  assign PIX_EN = 1'b1;
`endif

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h (
    .clk  (CLK),
    .rst  (RST),
    .en   (adv),
    .cnt  (x),
    .nxt  (h_nxt),
    .term (h_term),
    .sync (HS)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v (
    .clk  (CLK),
    .rst  (RST),
    .en   (adv & h_term),
    .cnt  (y),
    .nxt  (v_nxt),
    .term (v_term),
    .sync (VS)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DE          <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else if (adv) begin
      DE          <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      LINE_START  <= (h_nxt == '0);
      FRAME_START <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default 640x480 instance plus a tiny 16x10 instance with inverted sync polarity.
module tb_vga_timing;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rst_s = 1'b1;

  logic       hs, vs, de, ls, fs, pe;
  logic [9:0] x, y;
  logic       hs_s, vs_s, de_s, ls_s, fs_s, pe_s;
  logic [9:0] x_s, y_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  vga_timing dut (
    .CLK(CLK), .RST(RST), .HS(hs), .VS(vs), .x(x), .y(y), .DE(de),
    .LINE_START(ls), .FRAME_START(fs), .PIX_EN(pe)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .CLK(CLK), .RST(rst_s), .HS(hs_s), .VS(vs_s), .x(x_s), .y(y_s), .DE(de_s),
    .LINE_START(ls_s), .FRAME_START(fs_s), .PIX_EN(pe_s)
  );

`ifdef VGA_TIMING_PIXDIV2_EN
  localparam int CPP = 2;
`else
  localparam int CPP = 1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input int n);
    repeat (n * CPP) @(negedge CLK);
  endtask

  initial begin
    int hs_low, hs_first, de_cnt, ls_cnt, seq_err;
    int vs_hi, vs_first_y, vs_first_x, hs_hi, fs_cnt;

    // Reset held 5 cycles.
    repeat (5) @(negedge CLK);
    check("rst_x", x, 799);
    check("rst_y", y, 524);
    check("rst_de", de, 0);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_ls", ls, 0);
    check("rst_fs", fs, 0);
    check("rst_s_x", x_s, 15);
    check("rst_s_y", y_s, 9);
    check("rst_s_hs", hs_s, 0);
    check("rst_s_vs", vs_s, 0);

    RST = 1'b0;
    pix(1);
    check("first_x", x, 0);
    check("first_y", y, 0);
    check("first_de", de, 1);
    check("first_ls", ls, 1);
    check("first_fs", fs, 1);
    check("first_hs", hs, 1);

    // One full line on the default instance.
    hs_low = 0; hs_first = -1; de_cnt = 0; ls_cnt = 0; seq_err = 0;
    for (int i = 0; i < 800; i++) begin
      if (x != 10'(i) || y != 10'd0) seq_err++;
      if (hs == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      if (de) de_cnt++;
      if (ls) ls_cnt++;
      pix(1);
    end
    check("line_seq_err", seq_err, 0);
    check("line_hs_low", hs_low, 96);
    check("line_hs_first", hs_first, 656);
    check("line_de_cnt", de_cnt, 640);
    check("line_ls_cnt", ls_cnt, 1);
    check("line2_x", x, 0);
    check("line2_y", y, 1);
    check("line2_ls", ls, 1);
    check("line2_fs", fs, 0);
    check("line2_vs", vs, 1);

`ifdef VGA_TIMING_PIXDIV2_EN
    check("div_pe_hold", pe, 0);
    @(negedge CLK);
    check("div_pe_adv", pe, 1);
    check("div_x_adv", x, 1);
    @(negedge CLK);
    check("div_pe_hold2", pe, 0);
    check("div_x_hold", x, 1);
    check("div_ls_hold", ls, 0);
    pix(299);
`else
    check("pe_tied", pe, 1);
    pix(300);
`endif

    // Asynchronous reset mid-line, away from any clock edge.
    check("mid_x", x, 300);
    check("mid_y", y, 1);
    #1 RST = 1'b1;
    #1;
    check("async_x", x, 799);
    check("async_y", y, 524);
    check("async_de", de, 0);
    check("async_hs", hs, 1);
    check("async_vs", vs, 1);
    check("async_ls", ls, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    pix(1);
    check("restart_x", x, 0);
    check("restart_y", y, 0);
    check("restart_fs", fs, 1);
    pix(1);
    check("restart_x1", x, 1);
    check("restart_fs1", fs, 0);
    check("restart_ls1", ls, 0);

    // Full frame on the tiny inverted-polarity instance (16x10 total).
    rst_s = 1'b0;
    pix(1);
    check("s_first_x", x_s, 0);
    check("s_first_y", y_s, 0);
    check("s_first_fs", fs_s, 1);
    vs_hi = 0; vs_first_y = -1; vs_first_x = -1; hs_hi = 0; fs_cnt = 0; de_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      if (vs_s) begin
        vs_hi++;
        if (vs_first_y < 0) begin
          vs_first_y = int'(y_s);
          vs_first_x = int'(x_s);
        end
      end
      if (hs_s) hs_hi++;
      if (fs_s) fs_cnt++;
      if (de_s) de_cnt++;
      pix(1);
    end
    check("s_vs_hi", vs_hi, 32);
    check("s_vs_first_y", vs_first_y, 7);
    check("s_vs_first_x", vs_first_x, 0);
    check("s_hs_hi", hs_hi, 30);
    check("s_fs_cnt", fs_cnt, 1);
    check("s_de_cnt", de_cnt, 48);
    check("s_wrap_x", x_s, 0);
    check("s_wrap_y", y_s, 0);
    check("s_wrap_fs", fs_s, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
Upstream timing generator for the VGA pixel path. It produces HS, VS, pixel coordinates x/y, a data-enable and frame/line strobes, all from the single synthesized pixel clock. Downstream colour logic compares x/y against region bounds to drive Red/Green/Blue. Default timing is 640x480@60 (800x525 total).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of HS (0 = active-low)
- VS_POL, 0, asserted level of VS (0 = active-low)

Ports:
- CLK  in  1  pixel clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- HS  out  1  horizontal sync, registered
- VS  out  1  vertical sync, registered
- x  out  10  horizontal count, 0..H_TOTAL-1
- y  out  10  vertical count, 0..V_TOTAL-1
- DE  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- LINE_START  out  1  one-pixel strobe when x==0
- FRAME_START  out  1  one-pixel strobe when x==0 and y==0
- PIX_EN  out  1  pixel-advance qualifier (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Totals: H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525). Both must be ≤1024. 10-bit unsigned counters.
- Counter advance: on each PIX_EN cycle, x increments. At x==H_TOTAL-1, x wraps to 0 and y increments. At y==V_TOTAL-1 together with x wrap, y wraps to 0.
- All outputs are registered. Decode uses the next-state counter values, so HS/VS/DE/strobes and x/y are mutually aligned with zero skew.
- HS window: HS asserted (==HS_POL) for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751. Otherwise ~HS_POL.
- VS window: VS asserted (==VS_POL) for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, on every pixel of those lines. Otherwise ~VS_POL.
- Reset state: the generator parks at the last pixel of the frame. x=H_TOTAL-1 (799), y=V_TOTAL-1 (524), DE=0, HS=~HS_POL, VS=~VS_POL, LINE_START=0, FRAME_START=0.
- First active pixel: the first PIX_EN edge after RST falls yields x=0, y=0, DE=1, LINE_START=1, FRAME_START=1.
- Reset mid-frame: outputs return to the reset values immediately (async). Counting restarts as above; no partial-frame recovery.
- Hold behaviour: when PIX_EN=0, all outputs hold; strobes hold their value too. Consumers qualify strobes with PIX_EN.
- No other inputs; no illegal states are reachable. Counters beyond the terminal values (e.g. after an SEU) wrap on the next advance via a ≥ compare, not ==.

Optional Feature:
- Macro: VGA_TIMING_PIXDIV2_EN
- Defined: an internal toggle flop (reset 0) divides CLK by 2. PIX_EN is high every second cycle, first high on the first edge after reset release. Counters and outputs advance only when PIX_EN=1, which supports a 50 MHz CLK driving a 25 MHz pixel rate.
- Undefined: PIX_EN is tied to 1 and the counters advance every CLK.

Decomposition:
- Shared package/include: 640x480@60 timing constants (H_/V_ ACTIVE, FP, SYNC, BP), derived H_TOTAL/V_TOTAL, and sync polarity constants, for reuse by the colour/pattern stages.
- One natural sub-module: vga_axis_counter. It is a parameterised wrap counter with advance-enable, terminal-count output and sync-window decode. It is instantiated twice: horizontal (enable=PIX_EN) and vertical (enable=PIX_EN & h terminal).

Test Plan:
- Reset held 5 cycles, then released → during reset x=799, y=524, DE=0, HS=VS=1; first edge after release gives x=0, y=0, DE=1, FRAME_START=1.
- Run one full line → HS low for exactly 96 cycles starting at x=656; DE high for 640 cycles; LINE_START period 800 cycles.
- Run one full frame (420000 cycles) → VS low for exactly 1600 cycles (lines 490–491); FRAME_START pulses once; x/y return to 0/0.
- Assert RST asynchronously at x=300, y=200 → outputs jump to reset values without waiting for a clock edge; after release, counting restarts at 0/0.
- HS_POL=1, VS_POL=1 build → sync pulses inverted; windows unchanged.
- VGA_TIMING_PIXDIV2_EN defined → PIX_EN alternates 1/0; a line spans 1600 CLK cycles; outputs are stable across PIX_EN=0 cycles.
